// File: rtl/display_nhex.sv
// Multiplexed N-digit hex display driver with double-buffered frames.
// Define DISPLAY_NHEX_LZS_EN to enable leading-zero suppression.
module display_nhex #(
  parameter int NUM_DIGITS   = 8,
  parameter int DWELL_CYCLES = 8192
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic [3:0]              bright_in,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   strobe_out,
  output logic                    frame_out
);

  localparam int CW = $clog2(DWELL_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int STEP = DWELL_CYCLES / 16;
  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]             r_cnt;
  logic [IW-1:0]             r_idx;
  logic [4*NUM_DIGITS-1:0]   r_pend_data;
  logic [NUM_DIGITS-1:0]     r_pend_dp;
  logic [NUM_DIGITS-1:0]     r_pend_blank;
  logic                      r_pend_full;
  logic [4*NUM_DIGITS-1:0]   r_act_data;
  logic [NUM_DIGITS-1:0]     r_act_dp;
  logic [NUM_DIGITS-1:0]     r_act_blank;
  logic [6:0]                r_seg;
  logic                      r_dp;
  logic [NUM_DIGITS-1:0]     r_stb;
  logic                      r_frame;

  logic                      w_tc;
  logic                      w_wrap;
  logic                      w_xfer;
  logic                      w_cap;
  logic [CW:0]               w_thr;
  logic [IW-1:0]             w_pos;
  logic [3:0]                w_nib;
  logic                      w_blk;
  logic                      w_on;
  logic [6:0]                w_seg;
  logic                      w_dp;
  logic [NUM_DIGITS-1:0]     w_stb;
  logic [NUM_DIGITS-1:0]     w_lz;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h27;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign w_tc   = (r_cnt == CNT_MAX);
  assign w_wrap = w_tc && (r_idx == IDX_MAX);
  assign w_xfer = w_wrap && r_pend_full;
  assign w_cap  = valid_in && !r_pend_full;
  assign ready_out = ~r_pend_full;

  // Dwell counter and digit index; index steps at each dwell terminal count
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
      if (w_tc)
        r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
    end
  end

  // Pending buffer: filled by handshake, drained into active at frame wrap
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_pend_full  <= 1'b0;
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
    end else if (w_xfer) begin
      r_pend_full  <= 1'b0;
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
    end else if (w_cap) begin
      r_pend_full  <= 1'b1;
      r_pend_data  <= data_in;
      r_pend_dp    <= dp_in;
      r_pend_blank <= blank_in;
    end
  end

  // Active buffer only changes at a frame boundary so frames never tear
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_act_data  <= '0;
      r_act_dp    <= '0;
      r_act_blank <= '0;
    end else if (w_xfer) begin
      r_act_data  <= r_pend_data;
      r_act_dp    <= r_pend_dp;
      r_act_blank <= r_pend_blank;
    end
  end

`ifdef DISPLAY_NHEX_LZS_EN
  logic w_run;

  // Mark digits whose nibble and every nibble to the left are zero
  always_comb begin
    w_lz  = '0;
    w_run = 1'b1;
    for (int p = NUM_DIGITS - 1; p >= 1; p--) begin
      w_run   = w_run & (r_act_data[4*p +: 4] == 4'h0);
      w_lz[p] = w_run;
    end
  end
`else
  assign w_lz = '0;
`endif

  assign w_thr = (CW+1)'((int'(bright_in) + 1) * STEP);

  // Select the current digit and form next segment/strobe values
  always_comb begin
    w_pos = IDX_MAX - r_idx;
    w_nib = r_act_data[{w_pos, 2'b00} +: 4];
    w_blk = r_act_blank[w_pos] | w_lz[w_pos];
    w_on  = ({1'b0, r_cnt} < w_thr);
    w_seg = w_blk ? 7'h7F : hex7(w_nib);
    w_dp  = w_blk ? 1'b1 : ~r_act_dp[w_pos];
    w_stb = w_on ? ~(NUM_DIGITS'(1) << w_pos) : '1;
  end

  // Register display outputs and the frame pulse
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_seg   <= 7'h7F;
      r_dp    <= 1'b1;
      r_stb   <= '1;
      r_frame <= 1'b0;
    end else begin
      r_seg   <= w_seg;
      r_dp    <= w_dp;
      r_stb   <= w_stb;
      r_frame <= w_wrap;
    end
  end

  assign seg_out    = r_seg;
  assign dp_out     = r_dp;
  assign strobe_out = r_stb;
  assign frame_out  = r_frame;

endmodule

// File: tb/tb_display_nhex.sv
// Randomized self-checking bench for display_nhex (4 digits, dwell 16).
// Reference model predicts outputs from digit/frame arithmetic.
module tb_display_nhex;

  logic        clk;
  logic        rst_n;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        valid;
  logic        ready;
  logic [3:0]  bright;
  logic [6:0]  seg;
  logic        dpo;
  logic [3:0]  stb;
  logic        frame;

  int total = 0;
  int bad   = 0;

  logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                           7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h18, 7'h08, 7'h03,
                           7'h27, 7'h21, 7'h06, 7'h0E};

  // reference model state
  int          n;
  logic [15:0] act_d, pend_d;
  logic [3:0]  act_p, act_b, pend_p, pend_b;
  bit          pfull;

  display_nhex #(
    .NUM_DIGITS(4),
    .DWELL_CYCLES(16)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .data_in(data),
    .dp_in(dp),
    .blank_in(blank),
    .valid_in(valid),
    .ready_out(ready),
    .bright_in(bright),
    .seg_out(seg),
    .dp_out(dpo),
    .strobe_out(stb),
    .frame_out(frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h n=%0d", tag, got, exp, n);
    end
  endtask

  function automatic bit lzs(input logic [15:0] d, input int k);
`ifdef DISPLAY_NHEX_LZS_EN
    return (k < 3) && ((d >> (4 * (3 - k))) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    n = 0;
    act_d = '0; act_p = '0; act_b = '0;
    pend_d = '0; pend_p = '0; pend_b = '0;
    pfull = 1'b0;
  endtask

  task automatic check_reset_vals(input string t);
    check({t, "_seg"}, 16'(seg), 16'h7F);
    check({t, "_dp"}, 16'(dpo), 16'h1);
    check({t, "_stb"}, 16'(stb), 16'hF);
    check({t, "_frame"}, 16'(frame), 16'h0);
    check({t, "_ready"}, 16'(ready), 16'h1);
  endtask

  // one clock edge: predict, advance model, compare
  task automatic step();
    int c, k;
    logic [3:0] nib;
    bit blk, wrap, cap;
    logic [6:0] es;
    logic ed;
    logic [3:0] est;
    c = n % 16;
    k = (n / 16) % 4;
    nib = act_d[4*(3-k) +: 4];
    blk = act_b[3-k] || lzs(act_d, k);
    es = blk ? 7'h7F : HEX[nib];
    ed = blk ? 1'b1 : ~act_p[3-k];
    est = (c < int'(bright) + 1) ? ~(4'b0001 << (3 - k)) : 4'hF;
    wrap = (c == 15) && (k == 3);
    cap = valid && !pfull;
    if (wrap && pfull) begin
      act_d = pend_d; act_p = pend_p; act_b = pend_b;
      pfull = 1'b0;
    end
    if (cap) begin
      pend_d = data; pend_p = dp; pend_b = blank;
      pfull = 1'b1;
    end
    n++;
    @(posedge clk);
    #1;
    check("seg", 16'(seg), 16'(es));
    check("dp", 16'(dpo), 16'(ed));
    check("stb", 16'(stb), 16'(est));
    check("frame", 16'(frame), 16'(wrap));
    check("ready", 16'(ready), 16'(!pfull));
  endtask

  task automatic run(input bit v, input logic [15:0] d,
                     input logic [3:0] p, input logic [3:0] b);
    @(negedge clk);
    valid = v; data = d; dp = p; blank = b;
    step();
  endtask

  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++) run(1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; valid = 1'b0; data = '0;
    dp = '0; blank = '0; bright = 4'd15;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst0");
    rst_n = 1'b1;

    // scan with 1A2F at full brightness
    run(1'b1, 16'h1A2F, 4'h0, 4'h0);
    idle(64 * 3);

    // handshake: second request ignored while pending
    idle(20);
    run(1'b1, 16'h1234, 4'h0, 4'h0);
    run(1'b1, 16'h5678, 4'hF, 4'hF);
    idle(140);

    // brightness 3 then 0
    bright = 4'd3;
    idle(128);
    bright = 4'd0;
    idle(128);
    bright = 4'd15;

    // blank and decimal point
    run(1'b1, 16'hCDEF, 4'b0001, 4'b0100);
    idle(128);

    // leading zeros
    run(1'b1, 16'h0050, 4'h0, 4'h0);
    idle(128);
    run(1'b1, 16'h0000, 4'h0, 4'h0);
    idle(128);

    // capture on the same edge as the wrap
    guard = 0;
    while ((n % 64) != 63 && guard < 200) begin
      idle(1);
      guard++;
    end
    run(1'b1, 16'h9B07, 4'hA, 4'h0);
    idle(130);

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 31) == 0)
        bright = 4'($urandom_range(0, 15));
      run($urandom_range(0, 7) == 0, 16'($urandom),
          4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
    end

    // reset in digit 2 with a full pending buffer
    bright = 4'd15;
    guard = 0;
    while (!(((n / 16) % 4) == 2 && (n % 16) == 6 && pfull) && guard < 500) begin
      run(1'b1, 16'($urandom), 4'($urandom), 4'h0);
      guard++;
    end
    check("reach_d2", 16'(guard < 500), 16'h1);
    valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst_hold");
    rst_n = 1'b1;
    model_reset();
    idle(80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/display_nhex.md
DISPLAY_NHEX -- requirements
Module: display_nhex

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8: digit count, legal range 1..8.
REQ-002 SHALL have parameter DWELL_CYCLES, default 8192: clocks per digit, a multiple of 16 and at least 16.
REQ-003 SHALL have port clk_in  input  1  system clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n_in  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port data_in  input  4*NUM_DIGITS  hex nibbles, MSB nibble is leftmost digit.
REQ-006 SHALL have port dp_in  input  NUM_DIGITS  decimal-point enables, active-high, MSB is leftmost.
REQ-007 SHALL have port blank_in  input  NUM_DIGITS  per-digit blank, active-high, MSB is leftmost.
REQ-008 SHALL have port valid_in  input  1  frame-update request.
REQ-009 SHALL have port ready_out  output  1  pending buffer empty.
REQ-010 SHALL have port bright_in  input  4  brightness, 0 dimmest, 15 full.
REQ-011 SHALL have port seg_out  output  7  segments gfedcba, active-low.
REQ-012 SHALL have port dp_out  output  1  decimal point, active-low.
REQ-013 SHALL have port strobe_out  output  NUM_DIGITS  digit enables, active-low.
REQ-014 SHALL have port frame_out  output  1  one-cycle pulse at each frame start.

Function
REQ-015 SHALL count a dwell counter 0..DWELL_CYCLES-1; at terminal count, digit index k SHALL advance, wrapping NUM_DIGITS-1 to 0.
REQ-016 Digit index k SHALL display nibble data[4*(NUM_DIGITS-1-k)+:4] and drive strobe bit NUM_DIGITS-1-k low, all other bits high.
REQ-017 seg_out, dp_out and strobe_out SHALL be registered, one clock behind the counter and index state.
REQ-018 Hex decode SHALL be standard: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h18, A=7'h08, b=7'h03, c=7'h27, d=7'h21, E=7'h06, F=7'h0E.
REQ-019 Handshake: when valid_in and ready_out are both 1, data_in, dp_in and blank_in SHALL be captured into the pending buffer, and ready_out SHALL go 0 the next cycle.
REQ-020 While ready_out is 0, valid_in SHALL be ignored.
REQ-021 On the index wrap to 0, a full pending buffer SHALL copy to the active buffer, clear, and raise ready_out the next cycle.
REQ-022 A capture in the same cycle as a wrap SHALL NOT transfer until the following wrap.
REQ-023 frame_out SHALL pulse for one cycle on every wrap to 0, with or without a transfer.
REQ-024 The displayed contents SHALL come only from the active buffer, so a frame never tears.
REQ-025 Strobe SHALL be asserted only while dwell count < ((bright_in+1)*DWELL_CYCLES)/16; bright_in is sampled live.
REQ-026 A blanked digit SHALL drive seg_out=7'h7F and dp_out=1; its strobe SHALL still follow REQ-016 and REQ-025.
REQ-027 A non-blanked digit SHALL drive dp_out=~dp bit.
REQ-028 With NUM_DIGITS=1, index SHALL stay 0 and the wrap SHALL occur every DWELL_CYCLES clocks.

Reset
REQ-029 While rst_n_in is 0, all of the following SHALL hold: counter=0, index=0, active and pending buffers=0, seg_out=7'h7F, dp_out=1, strobe_out=all ones, frame_out=0, ready_out=1.
REQ-030 Reset mid-update SHALL discard pending data.
REQ-031 After reset release, scanning SHALL restart at digit index 0.

Configuration
REQ-032 With macro DISPLAY_NHEX_LZS_EN defined, leading-zero suppression SHALL be enabled: a digit whose nibble and all more-significant active nibbles are 0 SHALL be blanked as in REQ-026.
REQ-033 With DISPLAY_NHEX_LZS_EN defined, the least-significant digit SHALL never be suppressed.
REQ-034 Without DISPLAY_NHEX_LZS_EN, every digit SHALL display per REQ-018, and no suppression logic SHALL be synthesized.

Verification (NUM_DIGITS=4, DWELL_CYCLES=16 unless stated)
REQ-035 Scan: load 16'h1A2F, bright 15 -> strobe 4'b0111 shows 7'h79 for 16 clks, then 4'b1011/7'h08, 4'b1101/7'h24, 4'b1110/7'h0E, then repeat; frame_out every 64 clks.
REQ-036 Handshake: valid_in mid-frame with 16'h1234, then a second valid_in before the wrap -> ready_out 0, second request ignored, 1234 appears after the wrap, ready_out 1 the cycle after.
REQ-037 Brightness: bright_in=3 -> each strobe low for 4 of 16 clks; bright_in=0 -> low 1 of 16.
REQ-038 Blank/dp: blank_in=4'b0100, dp_in=4'b0001 -> digit 1 shows seg 7'h7F, digit 3 shows dp_out 0.
REQ-039 LZS (macro defined): load 16'h0050 -> digits 0 and 1 blank, digit 2 shows 7'h12, digit 3 shows 7'h40; load 16'h0000 -> only digit 3 shows 7'h40.
REQ-040 Reset: assert rst_n_in mid-digit-2 with a pending buffer full -> outputs take REQ-029 values immediately; after release, scan starts at digit 0 showing 7'h40.
